// File: rtl/mem_arb_pkg.sv
// Shared defaults and types for the memory arbiter.
// Provides parameter defaults and the read-return pipe entry.
package mem_arb_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_MEM_SIZE = 1000;

  typedef struct packed {
    logic [DEF_N_REQ-1:0] id;
    logic                 oob;
  } rd_ent_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: first request at or after the pointer wins.
// Ports: clk, rst (async low), req, advance (move pointer), gnt (comb).
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW:0]   idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) begin
        idx = idx - (PW+1)'(N);
      end
      if (!found && req[idx[PW-1:0]]) begin
        found               = 1'b1;
        win                 = idx[PW-1:0];
        gnt[idx[PW-1:0]]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (win == PW'(N-1)) ? '0 : win + PW'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem (write port + 1-cycle read port) among N_REQ clients.
// Ports: req/we/addr/wdata in, gnt/rvalid/rdata out, mem_* to storage.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int N_REQ    = DEF_N_REQ,
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int MEM_SIZE = DEF_MEM_SIZE,
  localparam int ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              we,
  input  logic [N_REQ-1:0][ADDR_W-1:0]  addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]  wdata,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_addr_w,
  output logic [DATA_W-1:0]             mem_data_in,
  output logic                          mem_read,
  output logic [ADDR_W-1:0]             mem_addr_r,
  input  logic [DATA_W-1:0]             mem_data_out
);

  logic [N_REQ-1:0]  wgnt;
  logic [N_REQ-1:0]  rgnt_raw;
  logic [N_REQ-1:0]  rgnt;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] wd;
  logic              wany;
  logic              rany;
  logic              hazard;
  logic              woob;
  logic              roob;
  rd_ent_t           pipe0;
  rd_ent_t           pipe1;

  rr_arbiter #(.N(N_REQ)) u_warb (
    .clk     (clk),
    .rst     (rst),
    .req     (req & we),
    .advance (wany),
    .gnt     (wgnt)
  );

  rr_arbiter #(.N(N_REQ)) u_rarb (
    .clk     (clk),
    .rst     (rst),
    .req     (req & ~we),
    .advance (rany),
    .gnt     (rgnt_raw)
  );

  always_comb begin
    waddr = '0;
    raddr = '0;
    wd    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (wgnt[i]) begin
        waddr = waddr | addr[i];
        wd    = wd | wdata[i];
      end
      if (rgnt_raw[i]) begin
        raddr = raddr | addr[i];
      end
    end
  end

  // Same-address read waits a cycle so it sees the new write data.
  assign hazard = (|wgnt) && (|rgnt_raw) && (waddr == raddr);
  assign rgnt   = hazard ? '0 : rgnt_raw;
  assign wany   = |wgnt;
  assign rany   = |rgnt;
  assign gnt    = rst ? (wgnt | rgnt) : '0;

  assign woob = ({1'b0, waddr} >= (ADDR_W+1)'(MEM_SIZE));
  assign roob = ({1'b0, raddr} >= (ADDR_W+1)'(MEM_SIZE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_write   <= 1'b0;
      mem_addr_w  <= '0;
      mem_data_in <= '0;
      mem_read    <= 1'b0;
      mem_addr_r  <= '0;
      pipe0       <= '0;
      pipe1       <= '0;
    end else begin
      mem_write <= wany & ~woob;
      if (wany) begin
        mem_addr_w  <= waddr;
        mem_data_in <= wd;
      end
      mem_read <= rany & ~roob;
      if (rany) begin
        mem_addr_r <= raddr;
      end
      pipe0.id  <= DEF_N_REQ'(rgnt);
      pipe0.oob <= rany & roob;
      pipe1     <= pipe0;
    end
  end

  assign rvalid = N_REQ'(pipe1.id);
  assign rdata  = pipe1.oob ? '0 : mem_data_out;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a behavioural model.
// Includes a simple mem model driving mem_data_out.
module tb_mem_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [3:0]       we;
  logic [3:0][9:0]  addr;
  logic [3:0][15:0] wdata;
  logic [3:0]       gnt;
  logic [3:0]       rvalid;
  logic [15:0]      rdata;
  logic             mem_write;
  logic [9:0]       mem_addr_w;
  logic [15:0]      mem_data_in;
  logic             mem_read;
  logic [9:0]       mem_addr_r;
  logic [15:0]      mem_data_out;

  int total = 0;
  int bad   = 0;

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .we           (we),
    .addr         (addr),
    .wdata        (wdata),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .mem_write    (mem_write),
    .mem_addr_w   (mem_addr_w),
    .mem_data_in  (mem_data_in),
    .mem_read     (mem_read),
    .mem_addr_r   (mem_addr_r),
    .mem_data_out (mem_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] bmem [0:1023] = '{default: '0};
  always @(posedge clk) begin
    if (mem_write) bmem[mem_addr_w] <= mem_data_in;
    if (mem_read) mem_data_out <= bmem[mem_addr_r];
  end

  typedef struct {
    int          due;
    int          id;
    logic [15:0] d;
  } ret_t;

  ret_t        rq[$];
  logic [15:0] mmem [0:1023] = '{default: '0};
  int          wptr, rptr, cyc;
  int          wwin, rwin, idx;
  logic [3:0]  m_gnt;
  logic        e_mw, e_mr;
  logic [9:0]  e_maw, e_mar;
  logic [15:0] e_md;
  logic [3:0]  ev;
  logic [15:0] ed;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic half_check();
    ret_t r;
    @(negedge clk);
    wwin = -1;
    rwin = -1;
    for (int k = 0; k < 4; k++) begin
      idx = (wptr + k) % 4;
      if (wwin < 0 && req[idx] && we[idx]) wwin = idx;
    end
    for (int k = 0; k < 4; k++) begin
      idx = (rptr + k) % 4;
      if (rwin < 0 && req[idx] && !we[idx]) rwin = idx;
    end
    if (wwin >= 0 && rwin >= 0 && addr[wwin] == addr[rwin]) rwin = -1;
    if (!rst) begin
      wwin = -1;
      rwin = -1;
    end
    m_gnt = '0;
    if (wwin >= 0) m_gnt[wwin] = 1'b1;
    if (rwin >= 0) m_gnt[rwin] = 1'b1;
    chk("gnt", 32'(gnt), 32'(m_gnt));
    ev = '0;
    ed = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      ev[r.id] = 1'b1;
      ed = r.d;
    end
    chk("rvalid", 32'(rvalid), 32'(ev));
    if (ev != 0) chk("rdata", 32'(rdata), 32'(ed));
    chk("mem_write", 32'(mem_write), 32'(e_mw));
    chk("mem_read", 32'(mem_read), 32'(e_mr));
    if (e_mw) begin
      chk("mem_addr_w", 32'(mem_addr_w), 32'(e_maw));
      chk("mem_data_in", 32'(mem_data_in), 32'(e_md));
    end
    if (e_mr) chk("mem_addr_r", 32'(mem_addr_r), 32'(e_mar));
    if (!rst) begin
      chk("rst_addr_w", 32'(mem_addr_w), 0);
      chk("rst_data_in", 32'(mem_data_in), 0);
      chk("rst_addr_r", 32'(mem_addr_r), 0);
    end
  endtask

  task automatic half_update();
    ret_t r;
    @(posedge clk);
    if (!rst) begin
      wptr = 0;
      rptr = 0;
      rq.delete();
      e_mw = 1'b0;
      e_mr = 1'b0;
    end else begin
      e_mw = (wwin >= 0) && (addr[wwin] < 10'd1000);
      e_mr = (rwin >= 0) && (addr[rwin] < 10'd1000);
      if (wwin >= 0) begin
        e_maw = addr[wwin];
        e_md  = wdata[wwin];
      end
      if (rwin >= 0) begin
        e_mar = addr[rwin];
        r.due = cyc + 2;
        r.id  = rwin;
        r.d   = (addr[rwin] >= 10'd1000) ? 16'h0 : mmem[addr[rwin]];
        rq.push_back(r);
        rptr = (rwin + 1) % 4;
      end
      if (wwin >= 0) begin
        if (addr[wwin] < 10'd1000) mmem[addr[wwin]] = wdata[wwin];
        wptr = (wwin + 1) % 4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic cycle();
    half_check();
    half_update();
  endtask

  task automatic drop_granted();
    req = req & ~m_gnt;
  endtask

  initial begin
    rst   = 1'b0;
    req   = 4'b1111;
    we    = 4'b0000;
    addr  = '0;
    wdata = '0;
    wptr  = 0;
    rptr  = 0;
    cyc   = 0;
    e_mw  = 1'b0;
    e_mr  = 1'b0;
    e_maw = '0;
    e_mar = '0;
    e_md  = '0;

    // reset state with requests held
    half_check();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    half_update();
    cycle();
    rst = 1'b1;

    // read rotation
    for (int i = 0; i < 4; i++) addr[i] = 10'(40 + i);
    for (int k = 0; k < 8; k++) begin
      half_check();
      chk("rot_gnt", 32'(gnt), 32'(1 << (k % 4)));
      half_update();
    end
    req = '0;
    repeat (3) cycle();

    // single requester write then read
    req = 4'b0001; we = 4'b0001; addr[0] = 10'd5; wdata[0] = 16'h1234;
    half_check();
    chk("t1_wgnt", 32'(gnt), 1);
    half_update();
    we = 4'b0000;
    half_check();
    chk("t1_rgnt", 32'(gnt), 1);
    half_update();
    req = '0;
    half_check();
    half_update();
    half_check();
    chk("t1_rvalid", 32'(rvalid), 1);
    chk("t1_rdata", 32'(rdata), 32'h1234);
    half_update();

    // same-address hazard
    req = 4'b0110; we = 4'b0010;
    addr[1] = 10'd7; wdata[1] = 16'hBEEF; addr[2] = 10'd7;
    half_check();
    chk("t3_gnt0", 32'(gnt), 32'b0010);
    half_update();
    drop_granted();
    half_check();
    chk("t3_gnt1", 32'(gnt), 32'b0100);
    half_update();
    drop_granted();
    half_check();
    half_update();
    half_check();
    chk("t3_rvalid", 32'(rvalid), 32'b0100);
    chk("t3_rdata", 32'(rdata), 32'hBEEF);
    half_update();

    // out-of-range read
    req = 4'b0001; we = 4'b0000; addr[0] = 10'd1000;
    half_check();
    chk("t4_gnt", 32'(gnt), 1);
    half_update();
    req = '0;
    half_check();
    chk("t4_mem_read", 32'(mem_read), 0);
    half_update();
    half_check();
    chk("t4_rvalid", 32'(rvalid), 1);
    chk("t4_rdata", 32'(rdata), 0);
    half_update();

    // simultaneous write and read
    req = 4'b1001; we = 4'b1000;
    addr[3] = 10'd10; wdata[3] = 16'h5A5A; addr[0] = 10'd20;
    half_check();
    chk("t5_gnt", 32'(gnt), 32'b1001);
    half_update();
    req = '0;
    half_check();
    chk("t5_mw", 32'(mem_write), 1);
    chk("t5_mr", 32'(mem_read), 1);
    half_update();
    repeat (2) cycle();

    // reset with reads in flight
    req = 4'b0011; we = 4'b0000; addr[0] = 10'd5; addr[1] = 10'd7;
    cycle();
    drop_granted();
    half_check();
    rst = 1'b0;
    half_update();
    req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      half_check();
      chk("t6_rvalid", 32'(rvalid), 0);
      chk("t6_gnt", 32'(gnt), 0);
      chk("t6_mw", 32'(mem_write), 0);
      chk("t6_mr", 32'(mem_read), 0);
      half_update();
    end
    rst = 1'b1;
    half_check();
    chk("t6_first", 32'(gnt), 1);
    half_update();
    req = '0;
    repeat (3) cycle();

    // randomized traffic honouring the hold-until-grant protocol
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && ($urandom % 2 == 0)) begin
          req[i]   = 1'b1;
          we[i]    = 1'($urandom % 2);
          addr[i]  = ($urandom % 10 == 0) ? 10'(1000 + $urandom % 24)
                                          : 10'($urandom % 8);
          wdata[i] = 16'($urandom);
        end
      end
      cycle();
      drop_granted();
    end
    req = '0;
    repeat (4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing one `mem` instance (separate write and read ports, 1-cycle registered read) between `N_REQ` requesters. Write and read ports are arbitrated independently, so one write and one read can be issued per cycle. The block registers the chosen commands onto the `mem` ports and routes read data back to the owning requester with a one-hot `rvalid`. It sits between client engines and the `mem` storage.

## Interface
- `N_REQ`, 4, number of requesters (≥2)
- `DATA_W`, 16, data width (matches `mem`)
- `MEM_SIZE`, 1000, words in `mem`; `ADDR_W = $clog2(MEM_SIZE)` (localparam)

Ports:
- `clk` in 1 clock, rising edge
- `rst` in 1 asynchronous, active-low reset
- `req` in N_REQ per-requester request
- `we` in N_REQ 1 = write, 0 = read
- `addr` in N_REQ×ADDR_W request address
- `wdata` in N_REQ×DATA_W write data
- `gnt` out N_REQ one-hot-per-port grant (combinational)
- `rvalid` out N_REQ one-hot read-data valid (registered)
- `rdata` out DATA_W read data, shared, valid where `rvalid` set
- `mem_write` out 1, `mem_addr_w` out ADDR_W, `mem_data_in` out DATA_W, mem write port
- `mem_read` out 1, `mem_addr_r` out ADDR_W, mem read port
- `mem_data_out` in DATA_W, mem read data

## Operation
- Requester holds `req`, `we`, `addr`, `wdata` stable until it sees `gnt`; transfer happens at the rising edge where `req & gnt`. `gnt` never asserts without `req`.
- Write arbiter: candidates are `req & we`; read arbiter: candidates are `req & ~we`. Each is round-robin with its own pointer; winner is the first candidate at or after the pointer (wrapping). On grant pointer ← winner+1 mod N_REQ; no grant → pointer unchanged.
- At most one write grant and one read grant per cycle, always to different requesters.
- Hazard: if both winners target the same address, the read grant is withheld that cycle (read pointer unchanged); the write proceeds.
- Address ≥ MEM_SIZE: request is granted, mem command suppressed (`mem_write`/`mem_read` stay 0); a suppressed read still returns `rvalid` with `rdata` = 0.
- Read return: 2-stage pipeline of {one-hot id, oob flag}; `rdata` = oob ? 0 : `mem_data_out`.

## Timing
- Cycle t: `gnt` asserted; edge E0 ends cycle t and registers mem command (`mem_*` valid in cycle t+1).
- Edge E1: mem performs write / captures read data.
- Read: `rvalid[i]` and `rdata` valid in cycle t+2 for exactly one cycle. Latency from grant cycle = 2.
- Back-to-back grants to the same requester every cycle are allowed; throughput 1 write + 1 read per cycle.
- Write then read of the same address by different requesters in consecutive grant cycles returns the new data.
- Reset (asserted any time, including with reads in flight): `gnt`, `rvalid`, `mem_write`, `mem_read` = 0; `mem_addr_*`, `mem_data_in`, `rdata` pipeline = 0; both pointers = 0; in-flight reads dropped with no `rvalid`.

## Structure
- Package `mem_arb_pkg`: default `DATA_W`, `MEM_SIZE`, `N_REQ`; typedef for read-pipe entry {id one-hot, oob}.
- Sub-module `rr_arbiter` (parameter N; ports `clk`, `rst`, `req`, `advance`, `gnt`): instantiated twice, for write and read. Hazard masking and pointer-hold done in `mem_arbiter` via `advance`.

## Test plan
- Single requester 0 writes 0x1234 to addr 5, then reads addr 5 → `rvalid[0]` 2 cycles after read grant, `rdata` = 0x1234.
- All 4 requesters hold read requests for 8 cycles → grants rotate 0,1,2,3,0,1,2,3; each `rvalid` follows its grant by 2 cycles.
- Req 1 writes addr 7 = 0xBEEF while req 2 reads addr 7 same cycle → only write granted; read granted next cycle and returns 0xBEEF.
- Req 0 reads addr 1000 (out of range) → granted, `mem_read` stays 0, `rvalid[0]` with `rdata` = 0.
- Simultaneous write (req 3, addr 10) and read (req 0, addr 20) → both granted same cycle, `mem_write` and `mem_read` both 1 next cycle.
- Assert `rst` low one cycle after two read grants → no `rvalid` appears; all outputs 0; after release first grant goes to requester 0.
